// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU and the multi-byte sequencer.
// Opcode encoding, flag bit positions and the per-byte control word.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBB = 4'd3;
  localparam logic [3:0] OP_INC = 4'd4;
  localparam logic [3:0] OP_DEC = 4'd5;
  localparam logic [3:0] OP_NEG = 4'd6;
  localparam logic [3:0] OP_SHL = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_NOT = 4'd9;
  localparam logic [3:0] OP_AND = 4'd10;
  localparam logic [3:0] OP_OR  = 4'd11;
  localparam logic [3:0] OP_XOR = 4'd12;
  localparam logic [3:0] OP_EXP = 4'd13;
  localparam logic [3:0] OP_SHR = 4'd14;
  localparam logic [3:0] OP_SAR = 4'd15;

  localparam int FZ = 0;
  localparam int FC = 1;
  localparam int FN = 2;
  localparam int FV = 3;

  typedef enum logic [1:0] { SEQ_IDLE, SEQ_RUN, SEQ_DONE } seq_state_e;

  typedef enum logic [0:0] { ASEL_OPA, ASEL_ZERO } asel_e;
  typedef enum logic [1:0] { BSEL_OPB, BSEL_OPA, BSEL_ZERO } bsel_e;
  typedef enum logic [1:0] { CSEL_CIN, CSEL_PREV, CSEL_ZERO } csel_e;

  typedef struct packed {
    logic [3:0] alu_op;
    asel_e      a_sel;
    bsel_e      b_sel;
    csel_e      c_sel;
    logic       fix_en;
    logic       v_en;
  } byte_ctl_t;

  // Right shifts walk the operand from the most significant byte down.
  function automatic logic msb_first(input logic [3:0] op);
    return (op == OP_SHR) || (op == OP_SAR);
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU; flags are {V,N,C,Z}, C is carry-out for adds
// and borrow for subtracts, shifted-out bit for shifts.
module alu
  import alu_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] op,
  input  logic       carry_in,
  output logic [7:0] result,
  output logic [3:0] flags
);

  logic [8:0] w_sum;
  logic       w_v;

  always_comb begin
    w_sum = 9'd0;
    case (op)
      OP_ADD: w_sum = {1'b0, a} + {1'b0, b};
      OP_ADC: w_sum = {1'b0, a} + {1'b0, b} + {8'd0, carry_in};
      OP_SUB: w_sum = {1'b0, a} - {1'b0, b};
      OP_SBB: w_sum = {1'b0, a} - {1'b0, b} - {8'd0, carry_in};
      OP_INC: w_sum = {1'b0, a} + 9'd1;
      OP_DEC: w_sum = {1'b0, a} - 9'd1;
      OP_NEG: w_sum = 9'd0 - {1'b0, a};
      OP_SHL: w_sum = {a, 1'b0};
      OP_SHR: w_sum = {a[0], 1'b0, a[7:1]};
      OP_SAR: w_sum = {a[0], a[7], a[7:1]};
      OP_MOV: w_sum = {1'b0, a};
      OP_NOT: w_sum = {1'b0, ~a};
      OP_AND: w_sum = {1'b0, a & b};
      OP_OR:  w_sum = {1'b0, a | b};
      OP_XOR: w_sum = {1'b0, a ^ b};
      OP_EXP: w_sum = {9{carry_in}};
      default: w_sum = 9'd0;
    endcase
    result = w_sum[7:0];

    w_v = 1'b0;
    case (op)
      OP_ADD, OP_ADC: w_v = (a[7] == b[7]) && (result[7] != a[7]);
      OP_SUB, OP_SBB: w_v = (a[7] != b[7]) && (result[7] != a[7]);
      OP_INC:         w_v = !a[7] && result[7];
      OP_DEC:         w_v = a[7] && !result[7];
      OP_NEG:         w_v = a[7] && result[7];
      OP_SHL:         w_v = a[7] ^ a[6];
      default:        w_v = 1'b0;
    endcase
    flags = {w_v, result[7], w_sum[8], (result == 8'd0)};
  end

endmodule

// File: rtl/alu_wide_seq_byte_map.sv
// Per-byte control decode: which ALU op, operands and carry a given step of a
// wide operation uses, and whether its result byte needs the bit-7 fixup.
module alu_byte_map
  import alu_pkg::*;
(
  input  logic [3:0] i_op,
  input  logic       i_first,
  input  logic       i_last,
  output byte_ctl_t  o_ctl
);

  always_comb begin
    o_ctl.alu_op = i_op;
    o_ctl.a_sel  = ASEL_OPA;
    o_ctl.b_sel  = BSEL_OPB;
    o_ctl.c_sel  = CSEL_CIN;
    o_ctl.fix_en = 1'b0;
    o_ctl.v_en   = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_ctl.c_sel = CSEL_ZERO;
        o_ctl.v_en  = i_last;
        if (!i_first) begin
          o_ctl.alu_op = OP_ADC;
          o_ctl.c_sel  = CSEL_PREV;
        end
      end
      OP_SUB: begin
        o_ctl.c_sel = CSEL_ZERO;
        o_ctl.v_en  = i_last;
        if (!i_first) begin
          o_ctl.alu_op = OP_SBB;
          o_ctl.c_sel  = CSEL_PREV;
        end
      end
      OP_ADC, OP_SBB: begin
        o_ctl.v_en = i_last;
        if (!i_first) o_ctl.c_sel = CSEL_PREV;
      end
      OP_INC: begin
        o_ctl.b_sel = BSEL_ZERO;
        o_ctl.c_sel = CSEL_ZERO;
        o_ctl.v_en  = i_last;
        if (!i_first) begin
          o_ctl.alu_op = OP_ADC;
          o_ctl.c_sel  = CSEL_PREV;
        end
      end
      OP_DEC: begin
        o_ctl.b_sel = BSEL_ZERO;
        o_ctl.c_sel = CSEL_ZERO;
        o_ctl.v_en  = i_last;
        if (!i_first) begin
          o_ctl.alu_op = OP_SBB;
          o_ctl.c_sel  = CSEL_PREV;
        end
      end
      // Negate as 0 - a so the borrow chains like a plain subtract.
      OP_NEG: begin
        o_ctl.alu_op = OP_SUB;
        o_ctl.a_sel  = ASEL_ZERO;
        o_ctl.b_sel  = BSEL_OPA;
        o_ctl.c_sel  = CSEL_ZERO;
        o_ctl.v_en   = i_last;
        if (!i_first) begin
          o_ctl.alu_op = OP_SBB;
          o_ctl.c_sel  = CSEL_PREV;
        end
      end
      OP_SHL: begin
        o_ctl.alu_op = OP_ADD;
        o_ctl.b_sel  = BSEL_OPA;
        o_ctl.c_sel  = CSEL_ZERO;
        o_ctl.v_en   = i_last;
        if (!i_first) begin
          o_ctl.alu_op = OP_ADC;
          o_ctl.c_sel  = CSEL_PREV;
        end
      end
      OP_SHR, OP_SAR: begin
        o_ctl.c_sel  = CSEL_ZERO;
        o_ctl.fix_en = !i_first;
        if (!i_first) o_ctl.alu_op = OP_SHR;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_wide_seq.sv
// Multi-byte sequencer: runs one wide operation through the 8-bit ALU, one
// byte per cycle with the carry chained, and assembles the wide result/flags.
module alu_wide_seq
  import alu_pkg::*;
#(
  parameter int BYTES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [3:0]           op,
  input  logic [8*BYTES-1:0]   a,
  input  logic [8*BYTES-1:0]   b,
  input  logic                 carry_in,
  output logic                 done_valid,
  input  logic                 done_ready,
  output logic [8*BYTES-1:0]   result,
  output logic [3:0]           flags,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [3:0]           alu_op,
  output logic                 alu_carry,
  input  logic [7:0]           alu_result,
  input  logic [3:0]           alu_flags
);

  localparam int W  = 8 * BYTES;
  localparam int SW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(BYTES - 1);

  seq_state_e    r_state, w_state_next;
  logic [3:0]    r_op;
  logic [W-1:0]  r_a, r_b;
  logic          r_cin;
  logic [SW-1:0] r_step, r_idx;
  logic          r_fix, r_v_en, r_prev_c, r_zero, r_n, r_v;
  logic          r_start_ready, r_done_valid;
  logic [W-1:0]  r_result;
  logic [3:0]    r_flags;
  logic [7:0]    r_alu_a, r_alu_b;
  logic [3:0]    r_alu_op;
  logic          r_alu_carry;

  logic          w_idle, w_run, w_accept, w_last_cap, w_load;
  logic [3:0]    w_map_op;
  logic [SW-1:0] w_load_step, w_load_idx;
  logic          w_map_last;
  byte_ctl_t     w_ctl;
  logic [W-1:0]  w_src_a, w_src_b;
  logic          w_src_cin;
  logic [7:0]    w_a_bytes [BYTES];
  logic [7:0]    w_b_bytes [BYTES];
  logic [7:0]    w_ld_a, w_ld_b;
  logic          w_ld_c;
  logic [7:0]    w_byte_fixed;
  logic          w_msb_cap, w_n, w_v, w_z;
  logic          w_unused_flags;

  assign w_idle     = (r_state == SEQ_IDLE);
  assign w_run      = (r_state == SEQ_RUN);
  assign w_accept   = w_idle && start_valid;
  assign w_last_cap = w_run && (r_step == LAST_STEP);
  assign w_load     = w_accept || (w_run && !w_last_cap);

  // Step 0 is decoded from the live inputs, later steps from the latched copy.
  assign w_map_op    = w_idle ? op : r_op;
  assign w_load_step = w_idle ? '0 : (r_step + SW'(1));
  assign w_map_last  = (w_load_step == LAST_STEP);
  assign w_load_idx  = msb_first(w_map_op) ? (LAST_STEP - w_load_step) : w_load_step;
  assign w_src_a     = w_idle ? a : r_a;
  assign w_src_b     = w_idle ? b : r_b;
  assign w_src_cin   = w_idle ? carry_in : r_cin;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign w_a_bytes[gi] = w_src_a[gi*8 +: 8];
      assign w_b_bytes[gi] = w_src_b[gi*8 +: 8];
    end
  endgenerate

  alu_byte_map u_map (
    .i_op    (w_map_op),
    .i_first (w_idle),
    .i_last  (w_map_last),
    .o_ctl   (w_ctl)
  );

  always_comb begin
    w_ld_a = w_a_bytes[w_load_idx];
    if (w_ctl.a_sel == ASEL_ZERO) w_ld_a = 8'd0;
    case (w_ctl.b_sel)
      BSEL_OPA:  w_ld_b = w_a_bytes[w_load_idx];
      BSEL_ZERO: w_ld_b = 8'd0;
      default:   w_ld_b = w_b_bytes[w_load_idx];
    endcase
    case (w_ctl.c_sel)
      CSEL_PREV: w_ld_c = alu_flags[FC];
      CSEL_ZERO: w_ld_c = 1'b0;
      default:   w_ld_c = w_src_cin;
    endcase
  end

  // Right-shift steps after the first pull the bit shifted out of the byte above.
  assign w_byte_fixed = r_fix ? {r_prev_c, alu_result[6:0]} : alu_result;
  assign w_msb_cap    = (r_idx == LAST_STEP);
  assign w_n          = w_msb_cap ? w_byte_fixed[7] : r_n;
  assign w_v          = w_msb_cap ? (r_v_en & alu_flags[FV]) : r_v;
  assign w_z          = r_zero & (w_byte_fixed == 8'd0);
  assign w_unused_flags = alu_flags[FZ] ^ alu_flags[FN];

  always_ff @(posedge clk) begin
    if (rst) r_state <= SEQ_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SEQ_IDLE: if (start_valid) w_state_next = SEQ_RUN;
      SEQ_RUN:  if (w_last_cap)  w_state_next = SEQ_DONE;
      SEQ_DONE: if (done_ready)  w_state_next = SEQ_IDLE;
      default:  w_state_next = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_start_ready <= 1'b1;
      r_done_valid  <= 1'b0;
      r_op          <= 4'd0;
      r_a           <= '0;
      r_b           <= '0;
      r_cin         <= 1'b0;
      r_step        <= '0;
      r_idx         <= '0;
      r_fix         <= 1'b0;
      r_v_en        <= 1'b0;
      r_prev_c      <= 1'b0;
      r_zero        <= 1'b0;
      r_n           <= 1'b0;
      r_v           <= 1'b0;
      r_result      <= '0;
      r_flags       <= 4'd0;
      r_alu_a       <= 8'd0;
      r_alu_b       <= 8'd0;
      r_alu_op      <= 4'd0;
      r_alu_carry   <= 1'b0;
    end else begin
      r_start_ready <= (w_state_next == SEQ_IDLE);
      r_done_valid  <= (w_state_next == SEQ_DONE);

      if (w_accept) begin
        r_op   <= op;
        r_a    <= a;
        r_b    <= b;
        r_cin  <= carry_in;
        r_step <= '0;
        r_zero <= 1'b1;
        r_n    <= 1'b0;
        r_v    <= 1'b0;
      end

      if (w_run) begin
        for (int i = 0; i < BYTES; i++) begin
          if (r_idx == SW'(i)) r_result[i*8 +: 8] <= w_byte_fixed;
        end
        r_prev_c <= alu_flags[FC];
        r_zero   <= w_z;
        r_n      <= w_n;
        r_v      <= w_v;
        r_step   <= r_step + SW'(1);
        if (w_last_cap) r_flags <= {w_v, w_n, alu_flags[FC], w_z};
      end

      if (w_load) begin
        r_alu_a     <= w_ld_a;
        r_alu_b     <= w_ld_b;
        r_alu_op    <= w_ctl.alu_op;
        r_alu_carry <= w_ld_c;
        r_idx       <= w_load_idx;
        r_fix       <= w_ctl.fix_en;
        r_v_en      <= w_ctl.v_en;
      end else if (w_last_cap) begin
        r_alu_a     <= 8'd0;
        r_alu_b     <= 8'd0;
        r_alu_op    <= 4'd0;
        r_alu_carry <= 1'b0;
      end
    end
  end

  assign start_ready = r_start_ready;
  assign done_valid  = r_done_valid;
  assign result      = r_result;
  assign flags       = r_flags;
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_op      = r_alu_op;
  assign alu_carry   = r_alu_carry;

endmodule

// File: tb/tb_alu_wide_seq.sv
// Bench for alu_wide_seq (BYTES=2) with a real 8-bit alu in the loop; expected
// results are queued at issue time and checked by an independent monitor.
module tb_alu_wide_seq;
  import alu_pkg::*;

  localparam int BYTES = 2;
  localparam int W     = 8 * BYTES;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [3:0]   op = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         done_valid;
  logic         done_ready = 1'b1;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic [7:0]   alu_a, alu_b, alu_result;
  logic [3:0]   alu_op, alu_flags;
  logic         alu_carry;

  always #5 clk = ~clk;

  alu_wide_seq #(.BYTES(BYTES)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .a(a), .b(b), .carry_in(carry_in),
    .done_valid(done_valid), .done_ready(done_ready),
    .result(result), .flags(flags),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_carry(alu_carry),
    .alu_result(alu_result), .alu_flags(alu_flags)
  );

  alu u_alu (
    .a(alu_a), .b(alu_b), .op(alu_op), .carry_in(alu_carry),
    .result(alu_result), .flags(alu_flags)
  );

  typedef struct packed {
    logic [7:0]   tag;
    logic [3:0]   flg;
    logic [W-1:0] res;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   tag_cnt = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, want);
    end
  endtask

  // Wide reference: whole-word arithmetic, flags {V,N,C,Z}.
  function automatic logic [W+3:0] ref_model(input logic [3:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y, input logic ci);
    logic [W:0]   s;
    logic [W-1:0] r;
    logic         v;
    s = '0;
    case (o)
      OP_ADD: s = {1'b0, x} + {1'b0, y};
      OP_ADC: s = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
      OP_SUB: s = {1'b0, x} - {1'b0, y};
      OP_SBB: s = {1'b0, x} - {1'b0, y} - (W+1)'(ci);
      OP_INC: s = {1'b0, x} + (W+1)'(1);
      OP_DEC: s = {1'b0, x} - (W+1)'(1);
      OP_NEG: s = (W+1)'(0) - {1'b0, x};
      OP_SHL: s = {x, 1'b0};
      OP_SHR: s = {x[0], 1'b0, x[W-1:1]};
      OP_SAR: s = {x[0], x[W-1], x[W-1:1]};
      OP_MOV: s = {1'b0, x};
      OP_NOT: s = {1'b0, ~x};
      OP_AND: s = {1'b0, x & y};
      OP_OR:  s = {1'b0, x | y};
      OP_XOR: s = {1'b0, x ^ y};
      default: s = {(W+1){ci}};
    endcase
    r = s[W-1:0];
    case (o)
      OP_ADD, OP_ADC: v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      OP_SUB, OP_SBB: v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      OP_INC:         v = !x[W-1] && r[W-1];
      OP_DEC:         v = x[W-1] && !r[W-1];
      OP_NEG:         v = x[W-1] && r[W-1];
      OP_SHL:         v = x[W-1] ^ x[W-2];
      default:        v = 1'b0;
    endcase
    return {v, r[W-1], s[W], (r == '0), r};
  endfunction

  task automatic issue(input logic [3:0] t_op, input logic [W-1:0] t_a,
                       input logic [W-1:0] t_b, input logic t_cin);
    int n = 0;
    while (!start_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!start_ready) check("start_ready_timeout", 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    op = t_op; a = t_a; b = t_b; carry_in = t_cin;
    @(posedge clk); #1;
    start_valid = 1'b0;
  endtask

  task automatic run(input logic [3:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                     input logic t_cin, input logic [W-1:0] e_res, input logic [3:0] e_flg);
    exp_t e;
    e.tag = 8'(tag_cnt);
    e.flg = e_flg;
    e.res = e_res;
    tag_cnt++;
    exp_q.push_back(e);
    issue(t_op, t_a, t_b, t_cin);
  endtask

  // Monitor: every consumed result is matched against the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done_valid && done_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          $display("[TB] op#%0d result=0x%04h flags=%04b (want 0x%04h %04b)",
                   e.tag, result, flags, e.res, e.flg);
          check("result", 32'(result), 32'(e.res));
          check("flags", 32'(flags), 32'(e.flg));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W+3:0] m;
    logic [3:0]   r_op_rand;
    logic [W-1:0] r_a_rand, r_b_rand;
    logic         r_c_rand;
    int           n;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_done_valid", 32'(done_valid), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_alu_bus", 32'({alu_a, alu_b, alu_op, alu_carry}), 32'd0);

    // ADD trace: step 0 is ADD FF+01, step 1 is ADC 00+00 with carry 1.
    run(OP_ADD, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 4'b0000);
    @(negedge clk);
    check("trace0_op", 32'(alu_op), 32'(OP_ADD));
    check("trace0_ab", 32'({alu_a, alu_b}), 32'h0000FF01);
    check("trace0_carry", 32'(alu_carry), 32'd0);
    check("trace0_not_done", 32'(done_valid), 32'd0);
    @(negedge clk);
    check("trace1_op", 32'(alu_op), 32'(OP_ADC));
    check("trace1_ab", 32'({alu_a, alu_b}), 32'h00000000);
    check("trace1_carry", 32'(alu_carry), 32'd1);
    check("trace1_not_done", 32'(done_valid), 32'd0);
    @(negedge clk);
    check("latency_done", 32'(done_valid), 32'd1);

    run(OP_SUB, 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 4'b0110);
    run(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1100);
    run(OP_SHL, 16'h8080, 16'h0000, 1'b0, 16'h0100, 4'b1010);
    run(OP_SHR, 16'h0101, 16'h0000, 1'b0, 16'h0080, 4'b0010);
    run(OP_SAR, 16'h8001, 16'h0000, 1'b0, 16'hC000, 4'b0110);
    run(OP_XOR, 16'h1234, 16'h1234, 1'b0, 16'h0000, 4'b0001);
    run(OP_AND, 16'hFF00, 16'h0F00, 1'b0, 16'h0F00, 4'b0000);
    run(OP_ADC, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 4'b0011);
    run(OP_SBB, 16'h0005, 16'h0003, 1'b1, 16'h0001, 4'b0000);
    run(OP_INC, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 4'b0011);
    run(OP_INC, 16'h7FFF, 16'h0000, 1'b0, 16'h8000, 4'b1100);
    run(OP_DEC, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 4'b0110);
    run(OP_DEC, 16'h8000, 16'h0000, 1'b0, 16'h7FFF, 4'b1000);
    run(OP_NEG, 16'h0001, 16'h0000, 1'b0, 16'hFFFF, 4'b0110);
    run(OP_NEG, 16'h8000, 16'h0000, 1'b0, 16'h8000, 4'b1110);
    run(OP_SHR, 16'h0001, 16'h0000, 1'b0, 16'h0000, 4'b0011);
    run(OP_EXP, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 4'b0110);
    run(OP_MOV, 16'h8001, 16'h0000, 1'b0, 16'h8001, 4'b0100);
    run(OP_NOT, 16'h00FF, 16'h0000, 1'b0, 16'hFF00, 4'b0100);

    // Backpressure: result must hold and a new start must be refused.
    n = 0;
    while (!start_ready && n < 100) begin @(posedge clk); #1; n++; end
    done_ready = 1'b0;
    run(OP_OR, 16'h1200, 16'h0034, 1'b0, 16'h1234, 4'b0000);
    n = 0;
    while (!done_valid && n < 20) begin @(negedge clk); n++; end
    check("bp_done_seen", 32'(done_valid), 32'd1);
    start_valid = 1'b1; op = OP_ADD; a = 16'h0001; b = 16'h0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(done_valid), 32'd1);
      check("bp_hold_result", 32'(result), 32'h1234);
      check("bp_hold_flags", 32'(flags), 32'd0);
      check("bp_start_blocked", 32'(start_ready), 32'd0);
    end
    @(posedge clk); #1;
    start_valid = 1'b0;
    done_ready  = 1'b1;
    repeat (4) @(negedge clk);
    check("bp_idle_ready", 32'(start_ready), 32'd1);
    check("bp_no_extra_done", 32'(done_valid), 32'd0);

    // Reset in the middle of RUN: the aborted op must never complete.
    issue(OP_ADD, 16'h0001, 16'h0001, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_start_ready", 32'(start_ready), 32'd1);
    check("midrst_done_valid", 32'(done_valid), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_flags", 32'(flags), 32'd0);
    check("midrst_alu_bus", 32'({alu_a, alu_b, alu_op, alu_carry}), 32'd0);
    repeat (4) @(negedge clk);
    check("midrst_no_done", 32'(done_valid), 32'd0);

    // Random sweep against the wide model, all opcodes.
    for (int i = 0; i < 48; i++) begin
      r_op_rand = 4'(i % 16);
      r_a_rand  = W'($urandom);
      r_b_rand  = W'($urandom);
      r_c_rand  = 1'($urandom_range(0, 1));
      m = ref_model(r_op_rand, r_a_rand, r_b_rand, r_c_rand);
      run(r_op_rand, r_a_rand, r_b_rand, r_c_rand, m[W-1:0], m[W+3:W]);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
